// File: rtl/trade_pkg.sv
// -----------------------------------------------------------------------------
// trade_pkg
// Shared types and constants for the trade order generator.
//   state_t         : order FSM states (IDLE, ISSUE, COOLDOWN)
//   side_t          : order side encoding (0 = buy, 1 = sell)
//   PRICE_FRAC_BITS : fractional bits of the 10.6 fixed-point price
// -----------------------------------------------------------------------------
package trade_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        COOLDOWN
    } state_t;

    typedef enum logic {
        SIDE_BUY  = 1'b0,
        SIDE_SELL = 1'b1
    } side_t;

    // Prices are carried through untouched; this documents their format.
    localparam int PRICE_FRAC_BITS = 6;

endpackage

// File: rtl/trade_order_gen_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Event counter that sticks at all-ones instead of wrapping.
//   clk   : clock
//   rst   : asynchronous active-low reset, clears the count
//   inc   : count one event this cycle
//   count : current count, saturating
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/trade_order_gen.sv
// -----------------------------------------------------------------------------
// trade_order_gen
// Turns buy/sell pulses from the Z-score stage into single-quantity market
// orders on a valid/ready port, holding net position within +/-MAX_POS and
// idling for COOLDOWN_CYCLES after each accepted order.
//   clk, rst            : clock, asynchronous active-low reset
//   data_valid_z        : qualifies buy_signal, sell_signal and price
//   buy_signal          : buy request
//   sell_signal         : sell request
//   price               : price sample (10.6 fixed point)
//   order_ready         : order sink accepts the presented order
//   order_valid         : order presented
//   order_side          : 0 = buy, 1 = sell
//   order_qty           : order quantity
//   order_price         : latched price of the order
//   position            : signed net position
//   reject_cnt          : limit/conflict rejections, saturating
//   drop_cnt            : events arriving while busy, saturating
// -----------------------------------------------------------------------------
module trade_order_gen
    import trade_pkg::*;
#(
    parameter int data_width      = 16,
    parameter int POS_WIDTH       = 16,
    parameter int ORDER_QTY       = 1,
    parameter int MAX_POS         = 8,
    parameter int COOLDOWN_CYCLES = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_valid_z,
    input  logic                  buy_signal,
    input  logic                  sell_signal,
    input  logic [data_width-1:0] price,
    input  logic                  order_ready,
    output logic                  order_valid,
    output logic                  order_side,
    output logic [POS_WIDTH-1:0]  order_qty,
    output logic [data_width-1:0] order_price,
    output logic [POS_WIDTH-1:0]  position,
    output logic [CNT_WIDTH-1:0]  reject_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    // Limit check runs one bit wider so position +/- qty cannot overflow.
    localparam logic signed [POS_WIDTH:0]   QTY_X = (POS_WIDTH+1)'(ORDER_QTY);
    localparam logic signed [POS_WIDTH:0]   MAX_X = (POS_WIDTH+1)'(MAX_POS);
    localparam logic signed [POS_WIDTH:0]   MIN_X = -MAX_X;
    localparam logic signed [POS_WIDTH-1:0] QTY_S = POS_WIDTH'(ORDER_QTY);

    // Cool-down timer counts COOLDOWN_CYCLES-1 down to 0.
    localparam int CD_W    = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam int CD_LOAD = (COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0;

    state_t                       state;
    state_t                       state_nxt;
    side_t                        side_q;
    side_t                        accept_side;
    logic [data_width-1:0]        price_q;
    logic [POS_WIDTH-1:0]         qty_q;
    logic signed [POS_WIDTH-1:0]  pos_q;
    logic signed [POS_WIDTH:0]    pos_x;
    logic [CD_W-1:0]              cd_cnt;

    logic ev;
    logic buy_ok;
    logic sell_ok;
    logic accept;
    logic reject;
    logic drop;
    logic handshake;

    assign ev      = data_valid_z & (buy_signal | sell_signal);
    assign pos_x   = {pos_q[POS_WIDTH-1], pos_q};
    assign buy_ok  = (pos_x + QTY_X) <= MAX_X;
    assign sell_ok = (pos_x - QTY_X) >= MIN_X;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        order_valid = 1'b0;
        accept      = 1'b0;
        reject      = 1'b0;
        drop        = 1'b0;
        handshake   = 1'b0;
        accept_side = SIDE_BUY;
        case (state)
            IDLE: begin
                if (ev) begin
                    if (buy_signal && sell_signal) begin
                        reject = 1'b1;
                    end else if (buy_signal) begin
                        accept      = buy_ok;
                        reject      = !buy_ok;
                        accept_side = SIDE_BUY;
                    end else begin
                        accept      = sell_ok;
                        reject      = !sell_ok;
                        accept_side = SIDE_SELL;
                    end
                end
                if (accept) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                order_valid = 1'b1;
                // Events never queue, including one in the handshake cycle.
                drop        = ev;
                if (order_ready) begin
                    handshake = 1'b1;
                    state_nxt = (COOLDOWN_CYCLES > 0) ? COOLDOWN : IDLE;
                end
            end
            COOLDOWN: begin
                drop = ev;
                if (cd_cnt == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Order fields, position and cool-down timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            side_q  <= SIDE_BUY;
            price_q <= '0;
            qty_q   <= '0;
            pos_q   <= '0;
            cd_cnt  <= '0;
        end else begin
            // Fields only change on acceptance, so they hold while idle and
            // stay stable throughout backpressure.
            if (accept) begin
                side_q  <= accept_side;
                price_q <= price;
                qty_q   <= POS_WIDTH'(ORDER_QTY);
            end
            if (handshake) begin
                pos_q <= (side_q == SIDE_BUY) ? pos_q + QTY_S : pos_q - QTY_S;
            end
            if (state != COOLDOWN && state_nxt == COOLDOWN) begin
                cd_cnt <= CD_W'(CD_LOAD);
            end else if (state == COOLDOWN && cd_cnt != '0) begin
                cd_cnt <= cd_cnt - CD_W'(1);
            end
        end
    end

    assign order_side  = logic'(side_q);
    assign order_qty   = qty_q;
    assign order_price = price_q;
    assign position    = pos_q;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_reject_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (reject),
        .count (reject_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (drop),
        .count (drop_cnt)
    );

endmodule

// File: doc/trade_order_gen.md
Name: trade_order_gen

Overview:
Downstream consumer of the Z-score signal stage. It takes the registered buy/sell pulses qualified by data_valid_z and turns them into single-quantity market orders on a valid/ready order port. It tracks net position against a symmetric limit, enforces a cool-down after each issued order, and counts rejected and dropped signals for monitoring.

Parameters:
data_width, 16, price width (10.6 fixed point, passed through unchanged)
POS_WIDTH, 16, signed net-position width
ORDER_QTY, 1, quantity per order (unsigned, fits POS_WIDTH-1 bits)
MAX_POS, 8, absolute position limit (positive, at most 2^(POS_WIDTH-1)-1)
COOLDOWN_CYCLES, 4, idle cycles after an accepted order (0 means none)
CNT_WIDTH, 16, width of the reject/drop counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
data_valid_z  in  1  qualifies buy_signal, sell_signal and price
buy_signal  in  1  buy request from the Z-score stage
sell_signal  in  1  sell request from the Z-score stage
price  in  data_width  price sample aligned with data_valid_z
order_ready  in  1  order sink accepts the order
order_valid  out  1  order presented
order_side  out  1  0 = buy, 1 = sell
order_qty  out  POS_WIDTH  order quantity
order_price  out  data_width  latched price
position  out  POS_WIDTH  signed net position
reject_cnt  out  CNT_WIDTH  limit or conflict rejections, saturating
drop_cnt  out  CNT_WIDTH  signals arriving while busy, saturating

Behaviour:
- Reset: when rst is low, all state clears asynchronously. State goes to IDLE. order_valid, order_side, order_qty, order_price, position, reject_cnt and drop_cnt all go to 0.
- Event: an event is a cycle where data_valid_z=1 and (buy_signal or sell_signal)=1. When data_valid_z=0, the signals are ignored.
- State machine states: IDLE, ISSUE, COOLDOWN.
- IDLE, event with both buy and sell high: no order; reject_cnt+1.
- IDLE, buy event: allowed if position+ORDER_QTY <= MAX_POS. Evaluate this in POS_WIDTH+1 signed arithmetic.
- IDLE, sell event: allowed if position-ORDER_QTY >= -MAX_POS.
- IDLE, event disallowed by the limit: reject_cnt+1; stay in IDLE.
- IDLE, event allowed: latch side, price and ORDER_QTY; go to ISSUE. order_valid rises on the next cycle, giving 1-cycle latency from event to order_valid.
- ISSUE: order_valid=1 and all order fields are held stable until order_ready=1.
- ISSUE, on the handshake edge (order_valid and order_ready):
  - position updates by +ORDER_QTY for a buy or -ORDER_QTY for a sell;
  - order_valid drops;
  - next state is COOLDOWN if COOLDOWN_CYCLES>0, otherwise IDLE.
- COOLDOWN: counter loads COOLDOWN_CYCLES-1 on entry and decrements each cycle. Leave for IDLE in the cycle the counter is 0, so the block spends exactly COOLDOWN_CYCLES cycles in COOLDOWN.
- Events in ISSUE or COOLDOWN: drop_cnt+1. This includes conflicting events; they never queue. An event in the handshake cycle counts as a drop.
- Counters: reject_cnt and drop_cnt saturate at all-ones.
- Position: never exceeds ±MAX_POS, by construction of the limit check.
- Order fields: hold their last values while order_valid=0.
- Reset mid-operation: a pending order is discarded and is not counted.

Decomposition:
- Package trade_pkg holds:
  - typedef enum state_t {IDLE, ISSUE, COOLDOWN};
  - typedef enum logic side_t {SIDE_BUY=0, SIDE_SELL=1};
  - the shared price fractional-bit constant (6).
- Sub-module sat_counter (parameter WIDTH; inputs clk, rst, inc; output count) is instantiated twice, for reject_cnt and drop_cnt.
- FSM, limit check and cool-down timer stay in trade_order_gen.

Test Plan:
- Basic buy: after reset, buy event with price=0x0640 and order_ready held 1. Required: order_valid high one cycle later with side=0, qty=1, price=0x0640. position becomes 1 after the handshake. Busy for 4 cycles, then IDLE.
- Backpressure and drop: sell event with order_ready=0 for 5 cycles. Required: order_valid and fields stable for all 5 cycles. A buy event at cycle 3 gives drop_cnt=1. After ready, position=-1.
- Limit reached: with MAX_POS=2, issue 2 buys, then a 3rd buy after cool-down. Required: no order on the 3rd buy, reject_cnt=1, position=2. A following sell is accepted and position=1.
- Conflict and invalid: an event with buy=sell=1 gives reject_cnt=1 and no order. buy=1 with data_valid_z=0 gives no order and no count change.
- Cool-down 0: with COOLDOWN_CYCLES=0, back-to-back events with ready=1 are accepted every 2 cycles, and drop_cnt counts only the handshake-cycle events.
- Async reset mid-ISSUE: pull rst low between clock edges while order_valid=1. Required: order_valid=0 immediately, position and counters 0, IDLE on release.
